encoder4to2_sync: RTL and testbench

Registered 4-to-2 line encoder with request capture and valid/ready output handshake. It is the return path for the 2-to-4 line decoder: 4 one-hot or multi-hot request lines are collected into a pending register. They are encoded one at a time into a 2-bit index that a downstream consumer (typically a decoder driving select lines) accepts with a handshake. No request is lost while the consumer stalls.

---
 rtl/encoder_pkg.sv | 21 ++
 rtl/prio_pick4.sv | 48 ++++
 rtl/encoder4to2_sync.sv | 115 +++++++++++
 tb/tb_encoder4to2_sync.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared sizes, FSM state type and reset values for the registered 4-to-2 encoder.
// Used by encoder4to2_sync and prio_pick4.
package encoder_pkg;

    localparam int N_LINES = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]   A_RST   = '0;
    localparam logic [N_LINES-1:0] P_RST   = '0;
    localparam logic [IDX_W-1:0]   PTR_RST = 2'b11;

    function automatic logic [N_LINES-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_LINES'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational picker over the pending vector: fixed highest-index priority by default,
// round-robin from i_start when ENCODER_RR_EN is defined. Zero latency, no backpressure.
module prio_pick4
    import encoder_pkg::*;
(
    input  logic [N_LINES-1:0] i_p,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx,
    output logic [N_LINES-1:0] o_clr
);

`ifdef ENCODER_RR_EN
    logic [IDX_W-1:0] w_cand;

    // Walk upward from i_start; the 2-bit add wraps 3 -> 0 naturally.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_LINES; k++) begin
            w_cand = i_start + IDX_W'(k);
            if (!o_found && i_p[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end
`else
    logic w_unused_start;
    assign w_unused_start = ^i_start;

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (i_p[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign o_clr = o_found ? idx2onehot(o_idx) : '0;

endmodule

// File: rtl/encoder4to2_sync.sv
// Registered 4-to-2 encoder: captures requests into P, grants one index per valid/ready transfer.
// Latency 2 cycles D->valid, 1 grant/cycle when ready; ready=0 freezes A/valid while P keeps collecting.
// Optional round-robin selection with ENCODER_RR_EN (otherwise fixed highest-index priority).
module encoder4to2_sync
    import encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] D,
    output logic [IDX_W-1:0]   A,
    output logic               valid,
    input  logic               ready,
    output logic [N_LINES-1:0] pend
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_LINES-1:0] r_pend;
    logic [N_LINES-1:0] w_pend_nxt;
    logic [N_LINES-1:0] w_clr;
    logic [N_LINES-1:0] w_pick_clr;
    logic [IDX_W-1:0]   r_a;
    logic [IDX_W-1:0]   w_a_nxt;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               w_found;
    logic               w_load;

`ifdef ENCODER_RR_EN
    logic [IDX_W-1:0] r_ptr;

    assign w_start = r_ptr + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_RST;
        end else if (w_load) begin
            r_ptr <= w_pick_idx;
        end
    end
`else
    assign w_start = '0;
`endif

    prio_pick4 u_pick (
        .i_p     (r_pend),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick_idx),
        .o_clr   (w_pick_clr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_found) begin
                    w_load      = 1'b1;
                    w_a_nxt     = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (w_found) begin
                        w_load  = 1'b1;
                        w_a_nxt = w_pick_idx;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
        // OR-ing D after the clear lets a same-cycle re-request survive.
        w_clr      = w_load ? w_pick_clr : '0;
        w_pend_nxt = (r_pend & ~w_clr) | D;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= P_RST;
            r_a     <= A_RST;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_a     <= w_a_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign A     = r_a;
    assign valid = r_valid;
    assign pend  = r_pend;

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_valid && !ready) |=> (r_valid && $stable(r_a)));

    a_valid_state: assert property (@(posedge clk) disable iff (!rst_n)
        r_valid == (r_state == HOLD));

endmodule

// File: tb/tb_encoder4to2_sync.sv
// Directed bench for encoder4to2_sync: grants go through a queue checked by a monitor,
// cycle-level state (pend/valid/A) is checked inline.
module tb_encoder4to2_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D;
    logic [1:0] A;
    logic       valid;
    logic       ready;
    logic [3:0] pend;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_q[$];

    // Grant sequences packed with element i in bits [2i+1:2i].
`ifdef ENCODER_RR_EN
    localparam logic [7:0] SEQ_RST   = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [7:0] SEQ_STALL = {2'd0, 2'd0, 2'd1, 2'd0};
    localparam logic [7:0] SEQ_MID   = {2'd2, 2'd1, 2'd0, 2'd3};
`else
    localparam logic [7:0] SEQ_RST   = {2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [7:0] SEQ_STALL = {2'd0, 2'd0, 2'd0, 2'd1};
    localparam logic [7:0] SEQ_MID   = {2'd0, 2'd1, 2'd2, 2'd3};
`endif

    encoder4to2_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .A     (A),
        .valid (valid),
        .ready (ready),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A transfer happens on the next rising edge whenever valid and ready are seen here.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got A=%0d, expected no grant", A);
            end else begin
                check("grant_A", {6'd0, A}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic back_to_back(input logic [7:0] seq);
        ready = 1'b1;
        D     = 4'b1111;
        tick();
        check("b2b_pend", pend, 4'b1111);
        D = 4'b0000;
        for (int i = 0; i < 4; i++) exp_q.push_back(seq[2*i +: 2]);
        tick();
        check("b2b_first_valid", valid, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("b2b_valid_run", valid, 1);
        end
        tick();
        check("b2b_valid_end", valid, 0);
        check("b2b_pend_end", pend, 0);
    endtask

    initial begin
        logic [1:0] s0;
        logic [1:0] s1;

        // Reset with all requests asserted
        D     = 4'b1111;
        ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_A", A, 0);
        check("rst_valid", valid, 0);
        check("rst_pend", pend, 0);
        tick();
        check("rst_pend_capture", pend, 4'b1111);
        check("rst_valid_still0", valid, 0);
        D = 4'b0000;
        tick();
        check("rst_first_valid", valid, 1);
        check("rst_first_A", A, SEQ_RST[1:0]);
        for (int i = 0; i < 4; i++) exp_q.push_back(SEQ_RST[2*i +: 2]);
        ready = 1'b1;
        repeat (4) tick();
        check("rst_drain_valid", valid, 0);
        check("rst_drain_pend", pend, 0);

        // Single one-cycle request
        D = 4'b0100;
        tick();
        check("single_pend", pend, 4'b0100);
        check("single_valid_early", valid, 0);
        D = 4'b0000;
        exp_q.push_back(2'd2);
        tick();
        check("single_valid", valid, 1);
        check("single_A", A, 2);
        check("single_pend_clr", pend, 0);
        tick();
        check("single_valid_end", valid, 0);

        // Stall with ready low
        ready = 1'b0;
        D     = 4'b0011;
        tick();
        check("stall_pend", pend, 4'b0011);
        D  = 4'b0000;
        s0 = SEQ_STALL[1:0];
        s1 = SEQ_STALL[3:2];
        exp_q.push_back(s0);
        exp_q.push_back(s1);
        tick();
        check("stall_pend_left", pend, 8'd1 << s1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid_hold", valid, 1);
            check("stall_A_hold", A, s0);
            tick();
        end
        ready = 1'b1;
        tick();
        check("stall_next_valid", valid, 1);
        check("stall_next_A", A, s1);
        tick();
        check("stall_valid_end", valid, 0);

        // Same-cycle clear and re-request of index 2
        ready = 1'b0;
        D     = 4'b0100;
        tick();
        check("simul_pend", pend, 4'b0100);
        tick();
        check("simul_valid", valid, 1);
        check("simul_A", A, 2);
        check("simul_pend_kept", pend, 4'b0100);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        ready = 1'b1;
        D     = 4'b0000;
        tick();
        check("simul_regrant_valid", valid, 1);
        check("simul_regrant_A", A, 2);
        check("simul_pend_clr", pend, 0);
        tick();
        check("simul_valid_end", valid, 0);

        back_to_back(SEQ_MID);

        // Asynchronous reset in the middle of a held grant
        ready = 1'b0;
        D     = 4'b0011;
        tick();
        D = 4'b0000;
        tick();
        check("arst_pre_valid", valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_A", A, 0);
        check("arst_pend", pend, 0);
        tick();
        rst_n = 1'b1;
        check("arst_hold_pend", pend, 0);

        // Selection state must be back at its reset value
        back_to_back(SEQ_RST);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
